// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a row of common-anode seven-segment
// digits. A prescaler divides the clock into digit slots. Each slot drives one
// active-low anode and presents that digit's hex nibble to an external
// seven-segment decoder. A PWM window at the start of each slot sets the
// brightness.
//
// New display values arrive over a valid/ready handshake into a one-entry
// pending buffer. They are copied into the display register only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Parameters
//   NUM_DIGITS  : number of digits scanned (2..8)
//   REFRESH_DIV : clock cycles per digit slot (>= 8)
//
// Optional feature
//   LEADING_ZERO_BLANK_EN : when defined, digits above the most significant
//                           nonzero nibble are blanked. Digit 0 is always shown.
//
// Ports
//   clock      : single clock; all logic on the rising edge
//   reset      : synchronous, active-high
//   load_valid : a new display value is offered on load_value
//   load_ready : a new value can be accepted (pending buffer empty, not in reset)
//   load_value : one hex nibble per digit; digit 0 is bits [3:0]
//   digit_mask : bit i = 1 enables digit i
//   brightness : PWM duty level 0..7 (7 = whole slot)
//   anode      : active-low digit select; at most one bit low
//   nibble     : nibble of the digit currently scanned
//   frame_done : one-cycle pulse after the last slot of each full scan
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic [2:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [3:0]              nibble,
  output logic                    frame_done
);

  // Prescaler and digit index widths.
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // DIV_W holds REFRESH_DIV itself, which needs one more bit than the counter
  // when REFRESH_DIV is a power of two. The duty multiplier (brightness + 1)
  // reaches 8, so four extra bits keep the product from overflowing.
  localparam int DIV_W = $clog2(REFRESH_DIV + 1);
  localparam int PWM_W = DIV_W + 4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PWM_W-1:0] DIV_EXT  = PWM_W'(REFRESH_DIV);

  logic [CNT_W-1:0]        presc_count;
  logic [IDX_W-1:0]        digit_index;
  logic                    slot_tick;
  logic                    frame_tick;

  logic [4*NUM_DIGITS-1:0] display_reg;
  logic [4*NUM_DIGITS-1:0] pending_reg;
  logic                    pending_full;
  logic                    handshake;

  logic [PWM_W-1:0]        duty_steps;
  logic [PWM_W-1:0]        pwm_limit;
  logic                    pwm_on;

  logic [3:0]              cur_nibble;
  logic                    cur_enabled;
  logic                    digit_lit;
  logic [NUM_DIGITS-1:0]   anode_next;

  // The slot tick is the wrap cycle of the prescaler. The frame tick is the
  // slot tick on the last digit.
  assign slot_tick  = (presc_count == CNT_LAST);
  assign frame_tick = slot_tick && (digit_index == IDX_LAST);

  // Ready is forced low during reset, even though pending_full is already
  // being cleared, so no handshake can occur while reset is held.
  assign load_ready = ~pending_full & ~reset;
  assign handshake  = load_valid & load_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_count <= '0;
      digit_index <= '0;
    end else begin
      if (slot_tick) begin
        presc_count <= '0;
        if (digit_index == IDX_LAST) begin
          digit_index <= '0;
        end else begin
          digit_index <= digit_index + IDX_W'(1);
        end
      end else begin
        presc_count <= presc_count + CNT_W'(1);
      end
    end
  end

  // One-entry pending buffer in front of the display register. A full buffer
  // holds ready low, so a handshake and a frame transfer can never involve a
  // full buffer on the same edge. A handshake on the frame tick with an empty
  // buffer only fills it. That value waits for the next frame boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      display_reg  <= '0;
      pending_reg  <= '0;
      pending_full <= 1'b0;
    end else if (frame_tick && pending_full) begin
      display_reg  <= pending_reg;
      pending_full <= 1'b0;
    end else if (handshake) begin
      pending_reg  <= load_value;
      pending_full <= 1'b1;
    end
  end

  // PWM window: the anode is on while
  //   count < ((brightness + 1) * REFRESH_DIV) / 8.
  // Brightness 7 gives exactly REFRESH_DIV, which is the whole slot.
  always_comb begin
    duty_steps = PWM_W'(brightness) + PWM_W'(1);
    pwm_limit  = (duty_steps * DIV_EXT) >> 3;
    pwm_on     = PWM_W'(presc_count) < pwm_limit;
  end

  // Select the nibble and mask bit of the digit being scanned. This is a
  // compare loop rather than an indexed part-select, so index values that are
  // never reached cannot read outside the vectors.
  always_comb begin
    cur_nibble  = 4'h0;
    cur_enabled = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_index == IDX_W'(i)) begin
        cur_nibble  = display_reg[4*i +: 4];
        cur_enabled = digit_mask[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] top_digit;

  // Find the most significant nonzero digit. The scan starts at digit 1, so
  // an all-zero value leaves top_digit at 0 and digit 0 stays visible.
  always_comb begin
    top_digit = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (display_reg[4*i +: 4] != 4'h0) begin
        top_digit = IDX_W'(i);
      end
    end
  end

  assign digit_lit = cur_enabled & pwm_on & ~(digit_index > top_digit);
`else
  assign digit_lit = cur_enabled & pwm_on;
`endif

  always_comb begin
    anode_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_lit && (digit_index == IDX_W'(i))) begin
        anode_next[i] = 1'b0;
      end
    end
  end

  // Output register. It adds one cycle of latency relative to the index and
  // prescaler, and keeps the pins glitch-free. frame_done is the frame tick
  // delayed by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode      <= '1;
      nibble     <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_next;
      nibble     <= cur_nibble;
      frame_done <= frame_tick;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Bench for display_scan_ctrl with NUM_DIGITS=3 and REFRESH_DIV=8.
//
// The reference model tracks the number of clock edges since reset. From that
// edge count it derives the slot position, the digit and the frame boundaries
// with plain division and modulo. It also keeps the pending/display values the
// way the handshake rules describe them. Each scenario task checks the DUT
// against this model and against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int ND    = 3;
  localparam int RD    = 8;
  localparam int FRAME = ND * RD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [11:0] load_value = 12'h000;
  logic [2:0]  digit_mask = 3'b111;
  logic [2:0]  brightness = 3'd7;
  logic [2:0]  anode;
  logic [3:0]  nibble;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] an_tab  [3] = '{3'b110, 3'b101, 3'b011};
  logic [3:0] nib_tab [3] = '{4'h5, 4'hA, 4'h3};

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .digit_mask (digit_mask),
    .brightness (brightness),
    .anode      (anode),
    .nibble     (nibble),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Reference model state. The m_* outputs are the values expected on the
  // DUT outputs after the most recent rising edge.
  int          m_k        = 0;
  logic [11:0] m_disp     = 12'h000;
  logic [11:0] m_pend     = 12'h000;
  logic        m_pend_full = 1'b0;
  logic [2:0]  m_anode    = 3'b111;
  logic [3:0]  m_nib      = 4'h0;
  logic        m_fd       = 1'b0;

  function automatic bit blanked(input logic [11:0] v, input int idx);
    int msd;
    msd = 0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < ND; i++) begin
      if (((v >> (4 * i)) & 12'h00F) != 12'h000) msd = i;
    end
    return idx > msd;
`else
    return (v == 12'hFFF) && (idx < msd);
`endif
  endfunction

  always @(posedge clock) begin : ref_model
    int cnt;
    int idx;
    bit frame;
    bit lit;
    bit hs;
    if (reset) begin
      m_k         = 0;
      m_disp      = 12'h000;
      m_pend_full = 1'b0;
      m_anode     = 3'b111;
      m_nib       = 4'h0;
      m_fd        = 1'b0;
    end else begin
      cnt   = m_k % RD;
      idx   = (m_k / RD) % ND;
      frame = (m_k % FRAME) == FRAME - 1;
      lit   = digit_mask[idx] && ((cnt + 1) * 8 <= (int'(brightness) + 1) * RD)
              && !blanked(m_disp, idx);
      m_anode = lit ? ~(3'b001 << idx) : 3'b111;
      m_nib   = 4'((m_disp >> (4 * idx)) & 12'h00F);
      m_fd    = frame;
      hs      = load_valid && !m_pend_full;
      if (frame && m_pend_full) begin
        m_disp      = m_pend;
        m_pend_full = 1'b0;
      end else if (hs) begin
        m_pend      = load_value;
        m_pend_full = 1'b1;
      end
      m_k++;
    end
  end

  // Stimulus helpers. These only advance time. They treat a missing
  // frame_done pulse as a failure.
  task automatic wait_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4 && !seen; i++) begin
      @(negedge clock);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL %s_frame_timeout: frame_done got none, required a pulse within %0d cycles",
               tag, 2 * FRAME + 4);
    end
  endtask

  // Offer a value just after a frame boundary. Return at the next
  // frame_done sample. The following FRAME samples show that value.
  task automatic load_word(input logic [11:0] v);
    wait_frame("load");
    load_value = v;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    wait_frame("load");
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_value = 12'hFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if ({anode, nibble, frame_done, load_ready} !== {3'b111, 4'h0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset_hold: got an=%b nib=%h fd=%b rdy=%b, required an=111 nib=0 fd=0 rdy=0",
                 anode, nibble, frame_done, load_ready);
      end
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({anode, nibble, load_ready} !== {3'b110, 4'h0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got an=%b nib=%h rdy=%b, required an=110 nib=0 rdy=1",
               anode, nibble, load_ready);
    end
    vectors++;
    if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
      miscompares++;
      $display("[TB] FAIL reset_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
               anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
    end
  endtask

  task automatic test_scan();
    digit_mask = 3'b111;
    brightness = 3'd7;
    load_word(12'h3A5);
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clock);
      vectors++;
      if ({anode, nibble, frame_done} !== {an_tab[j / RD], nib_tab[j / RD], 1'(j == FRAME - 1)}) begin
        miscompares++;
        $display("[TB] FAIL scan_seq j=%0d: got an=%b nib=%h fd=%b, required an=%b nib=%h fd=%b",
                 j, anode, nibble, frame_done, an_tab[j / RD], nib_tab[j / RD], j == FRAME - 1);
      end
      vectors++;
      if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
        miscompares++;
        $display("[TB] FAIL scan_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                 anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
      end
    end
  endtask

  task automatic test_brightness();
    int lows;
    int b;
    // Brightness 1 and then 0: the anode is low for 2 and then 1 cycles at
    // the start of each slot.
    for (int lvl = 1; lvl >= 0; lvl--) begin
      brightness = 3'(lvl);
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clock);
        vectors++;
        if (anode !== (((j % RD) < lvl + 1) ? an_tab[j / RD] : 3'b111)) begin
          miscompares++;
          $display("[TB] FAIL bright%0d_window j=%0d: got an=%b, required an=%b",
                   lvl, j, anode, ((j % RD) < lvl + 1) ? an_tab[j / RD] : 3'b111);
        end
      end
    end
    for (int f = 0; f < 4; f++) begin
      b = $urandom_range(0, 7);
      brightness = 3'(b);
      lows = 0;
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clock);
        if (anode !== 3'b111) lows++;
        vectors++;
        if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
          miscompares++;
          $display("[TB] FAIL bright_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                   anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
        end
        if ((j % RD) == RD - 1) begin
          vectors++;
          if (lows != b + 1) begin
            miscompares++;
            $display("[TB] FAIL bright_slot_len b=%0d: got %0d lit cycles, required %0d", b, lows, b + 1);
          end
          lows = 0;
        end
      end
    end
    brightness = 3'd7;
  endtask

  task automatic test_back_to_back();
    bit seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      vectors++;
      if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
        miscompares++;
        $display("[TB] FAIL b2b_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                 anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
      end
    end
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_ready_idle: got rdy=%b, required rdy=1", load_ready);
    end
    load_value = 12'h111;
    load_valid = 1'b1;
    @(negedge clock);
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_taken: got rdy=%b, required rdy=0", load_ready);
    end
    load_value = 12'h222;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clock);
      vectors++;
      if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
        miscompares++;
        $display("[TB] FAIL b2b_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                 anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
      end
      if (frame_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        vectors++;
        if (load_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_ready_low: got rdy=%b, required rdy=0 until boundary", load_ready);
        end
      end
    end
    vectors++;
    if (!seen || load_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_boundary: got fd_seen=%b rdy=%b, required fd_seen=1 rdy=1", seen, load_ready);
    end
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clock);
        if (f == 0 && j == 0) load_valid = 1'b0;
        vectors++;
        if ({nibble, load_ready} !== {4'(f + 1), 1'((f == 1) || (j == FRAME - 1))}) begin
          miscompares++;
          $display("[TB] FAIL b2b_frame%0d j=%0d: got nib=%h rdy=%b, required nib=%0d rdy=%b",
                   f, j, nibble, load_ready, f + 1, (f == 1) || (j == FRAME - 1));
        end
        vectors++;
        if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
          miscompares++;
          $display("[TB] FAIL b2b_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                   anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [11:0] vals [2] = '{12'h00F, 12'h000};
    logic [2:0]  exp_an;
    logic [3:0]  exp_nib;
    for (int v = 0; v < 2; v++) begin
      load_word(vals[v]);
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clock);
        exp_nib = (j / RD == 0) ? vals[v][3:0] : 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
        exp_an = (j / RD == 0) ? 3'b110 : 3'b111;
`else
        exp_an = an_tab[j / RD];
`endif
        vectors++;
        if ({anode, nibble} !== {exp_an, exp_nib}) begin
          miscompares++;
          $display("[TB] FAIL blank_%03h j=%0d: got an=%b nib=%h, required an=%b nib=%h",
                   vals[v], j, anode, nibble, exp_an, exp_nib);
        end
        vectors++;
        if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
          miscompares++;
          $display("[TB] FAIL blank_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                   anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
        end
      end
    end
  endtask

  task automatic test_mask();
    int lows;
    load_word(12'h3A5);
    digit_mask = 3'b010;
    lows = 0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clock);
      if (anode !== 3'b111) lows++;
      vectors++;
      if ({anode, frame_done} !== {((j / RD) % ND == 1) ? 3'b101 : 3'b111, 1'((j % FRAME) == FRAME - 1)}) begin
        miscompares++;
        $display("[TB] FAIL mask_010 j=%0d: got an=%b fd=%b, required an=%b fd=%b", j, anode, frame_done,
                 ((j / RD) % ND == 1) ? 3'b101 : 3'b111, (j % FRAME) == FRAME - 1);
      end
    end
    vectors++;
    if (lows != 2 * RD) begin
      miscompares++;
      $display("[TB] FAIL mask_lit_count: got %0d lit cycles, required %0d", lows, 2 * RD);
    end
    digit_mask = 3'b111;
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] exp_an;
    wait_frame("rst_mid");
    repeat (10) @(negedge clock);
    load_value = 12'h777;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_pending: got rdy=%b, required rdy=0", load_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if ({anode, nibble, frame_done, load_ready} !== {3'b111, 4'h0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_hold: got an=%b nib=%h fd=%b rdy=%b, required an=111 nib=0 fd=0 rdy=0",
                 anode, nibble, frame_done, load_ready);
      end
    end
    reset = 1'b0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
      exp_an = ((j / RD) % ND == 0) ? 3'b110 : 3'b111;
`else
      exp_an = an_tab[(j / RD) % ND];
`endif
      vectors++;
      if ({anode, nibble, load_ready} !== {exp_an, 4'h0, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_restart j=%0d: got an=%b nib=%h rdy=%b, required an=%b nib=0 rdy=1",
                 j, anode, nibble, load_ready, exp_an);
      end
      vectors++;
      if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_model: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                 anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      vectors++;
      if ({anode, nibble, frame_done, load_ready} !== {m_anode, m_nib, m_fd, ~m_pend_full & ~reset}) begin
        miscompares++;
        $display("[TB] FAIL random_model i=%0d: got an=%b nib=%h fd=%b rdy=%b, required an=%b nib=%h fd=%b rdy=%b",
                 i, anode, nibble, frame_done, load_ready, m_anode, m_nib, m_fd, ~m_pend_full & ~reset);
      end
      reset      = ($urandom_range(0, 149) == 0);
      load_valid = 1'($urandom_range(0, 1));
      load_value = 12'($urandom);
      if ($urandom_range(0, 15) == 0) digit_mask = 3'($urandom);
      if ($urandom_range(0, 7) == 0) brightness = 3'($urandom);
    end
    reset      = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    $display("[TB] display_scan_ctrl bench, NUM_DIGITS=%0d REFRESH_DIV=%0d", ND, RD);
    test_reset();
    test_scan();
    test_brightness();
    test_back_to_back();
    test_blanking();
    test_mask();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of seven-segment digits scanned (2..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (>= 8).
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all logic on posedge clock.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port load_valid, input, 1 bit, a new display value offered.
REQ-006 The block SHALL have port load_ready, output, 1 bit, asserted when a new value can be accepted.
REQ-007 The block SHALL have port load_value, input, 4*NUM_DIGITS bits, one hex nibble per digit; digit 0 is bits [3:0].
REQ-008 The block SHALL have port digit_mask, input, NUM_DIGITS bits; bit i=1 enables digit i.
REQ-009 The block SHALL have port brightness, input, 3 bits, PWM duty level 0..7.
REQ-010 The block SHALL have port anode, output, NUM_DIGITS bits, active-low digit select; at most one bit low.
REQ-011 The block SHALL have port nibble, output, 4 bits, the value for the external seven-segment decoder.
REQ-012 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse at the end of each full scan.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the slot tick.
REQ-014 Digit index SHALL advance by 1 on each slot tick and wrap from NUM_DIGITS-1 to 0; the wrap tick is the frame boundary.
REQ-015 frame_done SHALL be high for exactly the cycle after the frame-boundary tick.
REQ-016 A handshake SHALL occur when load_valid and load_ready are both high on a clock edge; load_value is captured into a pending buffer and pending_full is set.
REQ-017 load_ready SHALL equal NOT pending_full AND NOT reset.
REQ-018 On a frame-boundary tick with pending_full set, the display register SHALL take the pending value and pending_full SHALL clear; displayed digits never change mid-frame.
REQ-019 A handshake on the frame-boundary cycle itself (pending empty) SHALL fill pending only; that value is displayed from the following frame boundary.
REQ-020 PWM on-window SHALL be prescaler count < ((brightness+1)*REFRESH_DIV)>>3, computed at a width that cannot overflow; brightness=7 yields the full slot.
REQ-021 anode bit i SHALL be low iff index==i, digit_mask[i]=1, the PWM window is active, and the digit is not blanked (REQ-027); otherwise all bits SHALL be high.
REQ-022 nibble SHALL be the display-register nibble for the current index, regardless of blanking.
REQ-023 anode, nibble and frame_done SHALL be registered, lagging index/prescaler by exactly one cycle.
REQ-024 digit_mask and brightness SHALL be sampled every cycle; changes take effect at the next edge.

Reset
REQ-025 While reset is high the block SHALL hold: prescaler 0, index 0, display register 0, pending_full 0, anode all ones, nibble 0, frame_done 0, load_ready 0.
REQ-026 Reset asserted mid-frame or mid-handshake SHALL discard the pending value; scanning restarts at digit 0, count 0, on the first cycle after reset deasserts, with load_ready 1.

Configuration
REQ-027 With LEADING_ZERO_BLANK_EN defined, digits above the most significant nonzero nibble of the display register SHALL be blanked (anode held high); digit 0 is never blanked.
REQ-028 Without LEADING_ZERO_BLANK_EN, no blanking logic SHALL exist and every masked-in digit SHALL be driven per REQ-021.

Verification (NUM_DIGITS=3, REFRESH_DIV=8)
REQ-029 Reset released, load 0x3A5, mask 3'b111, brightness 7 -> after the first frame boundary, anode cycles 110,101,011 with nibble 5,A,3; each anode held 8 cycles; frame_done pulses every 24 cycles.
REQ-030 brightness 1 -> each digit's anode low for exactly 2 of 8 cycles at slot start; brightness 0 -> 1 cycle.
REQ-031 Two back-to-back loads 0x111 then 0x222 mid-frame -> first accepted, load_ready low until next boundary; 0x111 displayed, 0x222 accepted afterward and shown one frame later.
REQ-032 Load 0x00F with LEADING_ZERO_BLANK_EN -> digits 1,2 anode high; digit 0 shows F; without macro all three lit (0,0,F); load 0x000 -> digit 0 lit showing 0.
REQ-033 mask 3'b010 -> only anode 101 ever goes low; slot timing unchanged.
REQ-034 Reset pulse during digit 1 with pending full -> anode 111 during reset; afterward scan restarts at digit 0 showing 0, pending lost, load_ready 1.
